sha256_bit_seq: RTL and testbench

Bit-clock and word/round sequencer for the bit-serial SHA-256 datapath. Generates the slow bit strobe `bclk` and the per-bit `counter` consumed by the rotate, shift and add slices. Also generates round indexing and phase flags for the message-schedule and compression logic. Runs one full compression pass per `start`, with hold (stall) and done handshake.

---
 rtl/sha256_bit_seq.sv | 186 ++++++++++++++++++
 tb/tb_sha256_bit_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_bit_seq.sv
// Bit-clock, bit-counter and round sequencer for the bit-serial SHA-256 datapath.
// Optional finalize word pass (H += state) is enabled with `define SHA_SEQ_FINAL_EN.
module sha256_bit_seq #(
   parameter  int W          = 32,
   parameter  int ROUNDS     = 64,
   parameter  int MSG_ROUNDS = 16,
   parameter  int DIV        = 4,
   localparam int CW         = $clog2(W),
   localparam int RW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          hold_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          bclk_o,
   output logic [CW-1:0] counter_o,
   output logic [RW-1:0] round_o,
   output logic          word_first_o,
   output logic          word_last_o,
   output logic          msg_phase_o,
   output logic          final_o
);

   localparam int PW  = $clog2(DIV);
   localparam int RW1 = RW + 1;

   localparam logic [PW-1:0]  PH_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0]  PH_HALF  = PW'(DIV / 2);
   localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
   localparam logic [RW-1:0]  RND_LAST = RW'(ROUNDS - 1);
   localparam logic [RW1-1:0] MSG_LIM  = RW1'(MSG_ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DONE  = 2'd2
`ifdef SHA_SEQ_FINAL_EN
      , S_FINAL = 2'd3
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          bclk_q, bclk_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rnd_q, rnd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          wf_q, wl_q, mp_q;

   logic          wrap;
   logic [PW-1:0] ph_nx;
   logic          bclk_nx;

   // Phase wrap is the bclk falling edge; counter/round only move here.
   assign wrap    = (ph_q == PH_LAST);
   assign ph_nx   = wrap ? '0 : ph_q + PW'(1);
   assign bclk_nx = (ph_nx >= PH_HALF);

`ifdef SHA_SEQ_FINAL_EN
   logic fin_q, fin_d;
`endif

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bclk_d  = bclk_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SHA_SEQ_FINAL_EN
      fin_d   = fin_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               ph_d    = '0;
               bclk_d  = 1'b0;
               cnt_d   = '0;
               rnd_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (!hold_i) begin
               ph_d   = ph_nx;
               bclk_d = bclk_nx;
               if (wrap) begin
                  if (cnt_q != CNT_LAST) begin
                     cnt_d = cnt_q + CW'(1);
                  end else begin
                     cnt_d = '0;
                     if (rnd_q == RND_LAST) begin
                        rnd_d  = '0;
                        bclk_d = 1'b0;
`ifdef SHA_SEQ_FINAL_EN
                        state_d = S_FINAL;
                        fin_d   = 1'b1;
`else
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                     end else begin
                        rnd_d = rnd_q + RW'(1);
                     end
                  end
               end
            end
         end
`ifdef SHA_SEQ_FINAL_EN
         S_FINAL: begin
            if (!hold_i) begin
               ph_d   = ph_nx;
               bclk_d = bclk_nx;
               if (wrap) begin
                  if (cnt_q != CNT_LAST) begin
                     cnt_d = cnt_q + CW'(1);
                  end else begin
                     cnt_d   = '0;
                     bclk_d  = 1'b0;
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     fin_d   = 1'b0;
                  end
               end
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Flags are registered from next-state values so they are glitch-free.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         bclk_q  <= 1'b0;
         cnt_q   <= '0;
         rnd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wf_q    <= 1'b1;
         wl_q    <= 1'b0;
         mp_q    <= (MSG_ROUNDS > 0);
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bclk_q  <= bclk_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wf_q    <= (cnt_d == '0);
         wl_q    <= (cnt_d == CNT_LAST);
         mp_q    <= ({1'b0, rnd_d} < MSG_LIM);
      end
   end

`ifdef SHA_SEQ_FINAL_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) fin_q <= 1'b0;
      else       fin_q <= fin_d;
   end
   assign final_o = fin_q;
`else
   assign final_o = 1'b0;
`endif

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign bclk_o       = bclk_q;
   assign counter_o    = cnt_q;
   assign round_o      = rnd_q;
   assign word_first_o = wf_q;
   assign word_last_o  = wl_q;
   assign msg_phase_o  = mp_q;

endmodule

// File: tb/tb_sha256_bit_seq.sv
// Randomized bench for sha256_bit_seq against an elapsed-bit-time reference model.
module tb_sha256_bit_seq;

   localparam int TW = 4;
   localparam int TR = 2;
   localparam int TM = 1;
   localparam int TD = 4;
   localparam int CW = $clog2(TW);
   localparam int RW = (TR > 1) ? $clog2(TR) : 1;
`ifdef SHA_SEQ_FINAL_EN
   localparam int NBITS = TW * TR + TW;
`else
   localparam int NBITS = TW * TR;
`endif
   localparam int TOTAL = NBITS * TD;

   logic          clk, rst, start, hold;
   logic          busy_o, done_o, bclk_o, word_first_o, word_last_o, msg_phase_o, final_o;
   logic [CW-1:0] counter_o;
   logic [RW-1:0] round_o;

   sha256_bit_seq #(.W(TW), .ROUNDS(TR), .MSG_ROUNDS(TM), .DIV(TD)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .hold_i(hold),
      .busy_o(busy_o), .done_o(done_o), .bclk_o(bclk_o),
      .counter_o(counter_o), .round_o(round_o),
      .word_first_o(word_first_o), .word_last_o(word_last_o),
      .msg_phase_o(msg_phase_o), .final_o(final_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a pass is just TOTAL unstalled cycles; everything else is
   // derived from the elapsed count with division and remainder.
   int m_st = 0;      // 0 idle, 1 busy, 2 done
   int m_e = 0;
   int m_passes = 0;
   int stalls = 0;
   int acc_cyc = 0;
   int cyc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0;
         m_e  = 0;
      end else begin
         cyc++;
         case (m_st)
            0: if (start) begin m_st = 1; m_e = 0; acc_cyc = cyc; stalls = 0; end
            1: if (hold) stalls++;
               else begin
                  m_e++;
                  if (m_e == TOTAL) begin m_st = 2; m_e = 0; m_passes++; end
               end
            default: m_st = 0;
         endcase
      end
   end

   function automatic logic [31:0] pack(logic bsy, logic dn, logic bc, logic fn, int c, int r);
      logic wf, wl, mp;
      wf = (c == 0);
      wl = (c == TW - 1);
      mp = (r < TM);
      return {9'b0, bsy, dn, bc, fn, wf, wl, mp, 8'(r), 8'(c)};
   endfunction

   function automatic logic [31:0] exp_vec();
      int bi, c, r;
      logic bc, fn;
      c = 0; r = 0; bc = 1'b0; fn = 1'b0;
      if (m_st == 1) begin
         bi = m_e / TD;
         bc = (m_e % TD) >= TD / 2;
         if (bi >= TW * TR) begin fn = 1'b1; c = bi - TW * TR; end
         else begin c = bi % TW; r = bi / TW; end
      end
      return pack(m_st == 1, m_st == 2, bc, fn, c, r);
   endfunction

   logic [31:0] dut_vec;
   assign dut_vec = {9'b0, busy_o, done_o, bclk_o, final_o, word_first_o, word_last_o,
                     msg_phase_o, 8'(round_o), 8'(counter_o)};

   logic          prev_bclk = 1'b0;
   logic [CW-1:0] prev_cnt = '0;
   int            rises = 0;
   int            dut_dones = 0;
   int            last_done = -1;
   logic          period_en = 1'b0;

   always @(negedge clk) begin
      chk("state", dut_vec, exp_vec());
      if (m_st == 0) rises = 0;
      if (bclk_o && !prev_bclk) begin
         rises++;
         chk("cnt_at_rise", 32'(counter_o), 32'(prev_cnt));
      end
      if (done_o) begin
         chk("latency", cyc - acc_cyc, TOTAL + stalls);
         chk("rises", rises, NBITS);
         dut_dones++;
         if (period_en && last_done >= 0) chk("period", cyc - last_done, TOTAL + 2);
         last_done = cyc;
      end
      if (!period_en) last_done = -1;
      prev_bclk = bclk_o;
      prev_cnt  = counter_o;
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_o && n < budget) begin @(negedge clk); n++; end
      chk("timeout", 32'(done_o), 32'd1);
      @(negedge clk);
   endtask

   logic [31:0] rst_vec;

   initial begin
      rst = 1'b0; start = 1'b0; hold = 1'b0;
      rst_vec = pack(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      #2 rst = 1'b1;
      #1 chk("reset", dut_vec, rst_vec);
      @(negedge clk) rst = 1'b0;

      // clean pass
      pulse_start();
      wait_done(TOTAL * 4);

      // mid-bit stall at counter 2
      pulse_start();
      begin
         int n = 0;
         while (!(counter_o == 2 && bclk_o) && n < TOTAL * 2) begin @(negedge clk); n++; end
         chk("find_cnt2", 32'(counter_o == 2 && bclk_o), 32'd1);
      end
      hold = 1'b1;
      repeat (5) @(negedge clk);
      hold = 1'b0;
      wait_done(TOTAL * 4);

      // asynchronous reset between edges, then a clean restart
      pulse_start();
      repeat (TOTAL / 2) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("arst", dut_vec, rst_vec);
      @(negedge clk) rst = 1'b0;
      pulse_start();
      wait_done(TOTAL * 4);

      // start held high: back-to-back passes
      period_en = 1'b1;
      start = 1'b1;
      repeat (3 * (TOTAL + 2) + 3) @(negedge clk);
      start = 1'b0;
      period_en = 1'b0;
      repeat (TOTAL + 4) @(negedge clk);

      // random start/hold traffic
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         hold  = ($urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      hold  = 1'b0;
      repeat (TOTAL + 8) @(negedge clk);
      chk("passes", dut_dones, m_passes);
      chk("idle_end", 32'(busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
